sodor_tile_1stage_inductive_state_sink: RTL and testbench

SODOR_TILE_1STAGE_INDUCTIVE_STATE_SINK -- requirements
Module: sodor_tile_1stage_inductive_state_sink

---
 rtl/sodor_inductive_pkg.sv | 45 ++++
 rtl/sodor_inductive_state_cmp.sv | 19 +
 rtl/sodor_tile_1stage_inductive_state_sink.sv | 128 ++++++++++++
 tb/tb_sodor_tile_1stage_inductive_state_sink.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/sodor_inductive_pkg.sv
// Shared types for the inductive state sink: exported core state layout,
// field bit positions, mismatch-mask layout and the sink FSM encoding.
package sodor_inductive_pkg;

  localparam int STATE_W      = 35;
  localparam int BIT_MEM_EN   = 0;
  localparam int BIT_DMISS    = 1;
  localparam int BIT_INST_LSB = 2;
  localparam int BIT_INST_MSB = 33;
  localparam int BIT_IRQ      = 34;

  localparam int MASK_W      = 4;
  localparam int MASK_MEM_EN = 0;
  localparam int MASK_DMISS  = 1;
  localparam int MASK_INST   = 2;
  localparam int MASK_IRQ    = 3;

  // Packed so that bit 0 is mem_en and bit 34 is interrupt_edge.
  typedef struct packed {
    logic        interrupt_edge;
    logic [31:0] if_inst_buffer;
    logic        dmiss;
    logic        mem_en;
  } core_state_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    CHECKING = 2'd2,
    FAIL     = 2'd3
  } sink_state_e;

  function automatic core_state_t pack_state(input logic        mem_en,
                                             input logic        dmiss,
                                             input logic        interrupt_edge,
                                             input logic [31:0] if_inst_buffer);
    core_state_t s;
    s.mem_en         = mem_en;
    s.dmiss          = dmiss;
    s.interrupt_edge = interrupt_edge;
    s.if_inst_buffer = if_inst_buffer;
    return s;
  endfunction

endpackage

// File: rtl/sodor_inductive_state_cmp.sv
// Combinational left/right compare of the 35-bit exported core state,
// reduced to one mismatch bit per field.
module sodor_inductive_state_cmp
  import sodor_inductive_pkg::*;
(
  input  core_state_t              l_state,
  input  core_state_t              r_state,
  output logic [MASK_W-1:0]        mismatch
);

  always_comb begin
    mismatch              = '0;
    mismatch[MASK_MEM_EN] = (l_state.mem_en != r_state.mem_en);
    mismatch[MASK_DMISS]  = (l_state.dmiss != r_state.dmiss);
    mismatch[MASK_INST]   = (l_state.if_inst_buffer != r_state.if_inst_buffer);
    mismatch[MASK_IRQ]    = (l_state.interrupt_edge != r_state.interrupt_edge);
  end

endmodule

// File: rtl/sodor_tile_1stage_inductive_state_sink.sv
// Snapshot/compare/replay sink for two copies of the 1-stage tile state.
// Define INDUCTIVE_SINK_CYCLE_CNT_EN to build the saturating checked-cycle counter.
//
// state    | meaning
// IDLE     | no snapshot yet; waiting for snap_req
// ARMED    | snapshot held; compares and restores accepted
// CHECKING | at least one compare done; comparing on every check_en
// FAIL     | mismatch seen; everything frozen until reset
module sodor_tile_1stage_inductive_state_sink
  import sodor_inductive_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             l_reg_mem_en,
  input  logic             l_reg_dmiss,
  input  logic             l_reg_interrupt_edge,
  input  logic [31:0]      l_if_inst_buffer,
  input  logic             r_reg_mem_en,
  input  logic             r_reg_dmiss,
  input  logic             r_reg_interrupt_edge,
  input  logic [31:0]      r_if_inst_buffer,
  input  logic             snap_req,
  input  logic             check_en,
  input  logic             restore_req,
  output logic             snap_valid,
  output logic             restore_valid,
  output logic             restore_reg_mem_en,
  output logic             restore_reg_dmiss,
  output logic             restore_reg_interrupt_edge,
  output logic [31:0]      restore_if_inst_buffer,
  output logic             violation,
  output logic [3:0]       violation_mask,
  output logic [CNT_W-1:0] checked_cycles
);

  sink_state_e       state_q, state_d;
  core_state_t       l_state, r_state;
  core_state_t       snap_q;
  core_state_t       restore_q;
  logic              restore_valid_q;
  logic              violation_q;
  logic [MASK_W-1:0] mask_q;
  logic [MASK_W-1:0] mismatch;
  logic              capture, compare_act, restore_act;

  assign l_state = pack_state(l_reg_mem_en, l_reg_dmiss, l_reg_interrupt_edge, l_if_inst_buffer);
  assign r_state = pack_state(r_reg_mem_en, r_reg_dmiss, r_reg_interrupt_edge, r_if_inst_buffer);

  sodor_inductive_state_cmp u_cmp (
    .l_state  (l_state),
    .r_state  (r_state),
    .mismatch (mismatch)
  );

  always_comb begin
    state_d     = state_q;
    capture     = 1'b0;
    compare_act = 1'b0;
    restore_act = 1'b0;
    case (state_q)
      IDLE: begin
        if (snap_req) begin
          capture = 1'b1;
          state_d = ARMED;
        end
      end
      ARMED, CHECKING: begin
        capture     = snap_req;
        restore_act = restore_req;
        if (check_en) begin
          compare_act = 1'b1;
          state_d     = (|mismatch) ? FAIL : CHECKING;
        end
      end
      FAIL:    state_d = FAIL;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      snap_q          <= '0;
      restore_q       <= '0;
      restore_valid_q <= 1'b0;
      violation_q     <= 1'b0;
      mask_q          <= '0;
    end else begin
      state_q         <= state_d;
      restore_valid_q <= restore_act;
      // Restore reads the snapshot before any same-cycle capture lands.
      restore_q       <= restore_act ? snap_q : '0;
      if (capture) snap_q <= l_state;
      if (compare_act && (|mismatch)) begin
        violation_q <= 1'b1;
        mask_q      <= mask_q | mismatch;
      end
    end
  end

`ifdef INDUCTIVE_SINK_CYCLE_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (compare_act && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign checked_cycles = cnt_q;
`else
  assign checked_cycles = {CNT_W{1'b0}};
`endif

  assign snap_valid                 = (state_q != IDLE);
  assign restore_valid              = restore_valid_q;
  assign restore_reg_mem_en         = restore_q.mem_en;
  assign restore_reg_dmiss          = restore_q.dmiss;
  assign restore_reg_interrupt_edge = restore_q.interrupt_edge;
  assign restore_if_inst_buffer     = restore_q.if_inst_buffer;
  assign violation                  = violation_q;
  assign violation_mask             = mask_q;

endmodule

// File: tb/tb_sodor_tile_1stage_inductive_state_sink.sv
// Bench for the inductive state sink: directed vector table, hand-written
// counter/saturation sequence, and randomized traffic against a reference model.
module tb_sodor_tile_1stage_inductive_state_sink;

  logic        clock = 1'b0;
  logic        reset;
  logic        l_mem, l_dmiss, l_irq, r_mem, r_dmiss, r_irq;
  logic [31:0] l_inst, r_inst;
  logic        snap_req, check_en, restore_req;

  logic        snap_valid, restore_valid, rs_mem, rs_dmiss, rs_irq, violation;
  logic [31:0] rs_inst;
  logic [3:0]  violation_mask;
  logic [15:0] checked_cycles;

  logic        snap_valid_4, restore_valid_4, rs_mem_4, rs_dmiss_4, rs_irq_4, violation_4;
  logic [31:0] rs_inst_4;
  logic [3:0]  violation_mask_4;
  logic [3:0]  checked_cycles_4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  sodor_tile_1stage_inductive_state_sink dut (
    .clock(clock), .reset(reset),
    .l_reg_mem_en(l_mem), .l_reg_dmiss(l_dmiss), .l_reg_interrupt_edge(l_irq), .l_if_inst_buffer(l_inst),
    .r_reg_mem_en(r_mem), .r_reg_dmiss(r_dmiss), .r_reg_interrupt_edge(r_irq), .r_if_inst_buffer(r_inst),
    .snap_req(snap_req), .check_en(check_en), .restore_req(restore_req),
    .snap_valid(snap_valid), .restore_valid(restore_valid),
    .restore_reg_mem_en(rs_mem), .restore_reg_dmiss(rs_dmiss),
    .restore_reg_interrupt_edge(rs_irq), .restore_if_inst_buffer(rs_inst),
    .violation(violation), .violation_mask(violation_mask), .checked_cycles(checked_cycles)
  );

  sodor_tile_1stage_inductive_state_sink #(.CNT_W(4)) dut4 (
    .clock(clock), .reset(reset),
    .l_reg_mem_en(l_mem), .l_reg_dmiss(l_dmiss), .l_reg_interrupt_edge(l_irq), .l_if_inst_buffer(l_inst),
    .r_reg_mem_en(r_mem), .r_reg_dmiss(r_dmiss), .r_reg_interrupt_edge(r_irq), .r_if_inst_buffer(r_inst),
    .snap_req(snap_req), .check_en(check_en), .restore_req(restore_req),
    .snap_valid(snap_valid_4), .restore_valid(restore_valid_4),
    .restore_reg_mem_en(rs_mem_4), .restore_reg_dmiss(rs_dmiss_4),
    .restore_reg_interrupt_edge(rs_irq_4), .restore_if_inst_buffer(rs_inst_4),
    .violation(violation_4), .violation_mask(violation_mask_4), .checked_cycles(checked_cycles_4)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Expected counter value after n compares for a counter of width w.
  function automatic longint exp_cnt(input longint n, input int w);
    longint lim;
    lim = (longint'(1) << w) - 1;
`ifdef INDUCTIVE_SINK_CYCLE_CNT_EN
    return (n > lim) ? lim : n;
`else
    return 0;
`endif
  endfunction

  task automatic drive(input bit rst, input bit snap, input bit chk, input bit rest,
                       input bit lm, input bit ld, input bit li, input logic [31:0] linst,
                       input bit rm, input bit rd, input bit ri, input logic [31:0] rinst);
    reset = rst; snap_req = snap; check_en = chk; restore_req = rest;
    l_mem = lm; l_dmiss = ld; l_irq = li; l_inst = linst;
    r_mem = rm; r_dmiss = rd; r_irq = ri; r_inst = rinst;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    bit          rst, snap, chk, rest;
    logic [31:0] l_inst, r_inst;
    bit          l_dmiss, r_dmiss;
    bit          e_sv, e_rv;
    logic [31:0] e_ri;
    bit          e_v;
    logic [3:0]  e_m;
    int          e_cnt;
  } vec_t;

  function automatic vec_t mk(input bit rst, input bit snap, input bit chk, input bit rest,
                              input logic [31:0] li, input logic [31:0] ri, input bit ld, input bit rd,
                              input bit sv, input bit rv, input logic [31:0] rinst,
                              input bit v, input logic [3:0] m, input int cnt);
    vec_t t;
    t.rst = rst; t.snap = snap; t.chk = chk; t.rest = rest;
    t.l_inst = li; t.r_inst = ri; t.l_dmiss = ld; t.r_dmiss = rd;
    t.e_sv = sv; t.e_rv = rv; t.e_ri = rinst; t.e_v = v; t.e_m = m; t.e_cnt = cnt;
    return t;
  endfunction

  // Reference model: a live snapshot is either held or not; failure freezes it.
  bit          m_has_snap, m_failed, m_checking, m_viol;
  logic [34:0] m_snap;
  logic [3:0]  m_mask;
  bit          m_rv;
  logic [34:0] m_rdata;
  longint      m_cnt;

  task automatic model_step(input bit rst, input bit snap, input bit chk, input bit rest,
                            input logic [34:0] l, input logic [34:0] r);
    logic [3:0] diff;
    bit live, failed_prev;
    if (rst) begin
      m_has_snap = 0; m_failed = 0; m_checking = 0; m_viol = 0;
      m_snap = '0; m_mask = '0; m_rv = 0; m_rdata = '0; m_cnt = 0;
      return;
    end
    diff[0] = l[0] != r[0];
    diff[1] = l[1] != r[1];
    diff[2] = l[33:2] != r[33:2];
    diff[3] = l[34] != r[34];
    failed_prev = m_failed;
    live = m_has_snap && !m_failed;
    m_rv = live && rest;
    m_rdata = m_rv ? m_snap : '0;
    if (live && chk) begin
      m_cnt++;
      m_checking = 1;
      if (diff != 0) begin
        m_failed = 1; m_viol = 1; m_mask |= diff;
      end
    end
    if (!failed_prev && snap) begin
      m_snap = l;
      m_has_snap = 1;
    end
  endtask

  vec_t tbl[12];
  logic [34:0] l_vec, r_vec;

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Directed table: one input cycle per row, outputs sampled after the edge.
    tbl[0]  = mk(1,0,0,0, 32'h0,        32'h0,  0,0, 0,0,32'h0,        0,4'b0000,0);
    tbl[1]  = mk(0,1,0,0, 32'h13,       32'h0,  0,0, 1,0,32'h0,        0,4'b0000,0);
    tbl[2]  = mk(0,0,0,1, 32'h0,        32'h0,  0,0, 1,1,32'h13,       0,4'b0000,0);
    tbl[3]  = mk(0,0,0,0, 32'h0,        32'h0,  0,0, 1,0,32'h0,        0,4'b0000,0);
    tbl[4]  = mk(0,1,0,1, 32'hDEADBEEF, 32'h0,  0,0, 1,1,32'h13,       0,4'b0000,0);
    tbl[5]  = mk(0,0,0,1, 32'h0,        32'h0,  0,0, 1,1,32'hDEADBEEF, 0,4'b0000,0);
    tbl[6]  = mk(0,0,0,1, 32'h0,        32'h0,  0,0, 1,1,32'hDEADBEEF, 0,4'b0000,0);
    tbl[7]  = mk(0,0,1,0, 32'h55,       32'h55, 0,0, 1,0,32'h0,        0,4'b0000,1);
    tbl[8]  = mk(0,0,1,0, 32'h55,       32'h66, 0,1, 1,0,32'h0,        1,4'b0110,2);
    tbl[9]  = mk(0,1,1,1, 32'h1234,     32'h77, 1,0, 1,0,32'h0,        1,4'b0110,2);
    tbl[10] = mk(1,1,1,0, 32'h1,        32'h2,  0,1, 0,0,32'h0,        0,4'b0000,0);
    tbl[11] = mk(0,0,1,1, 32'h1,        32'h2,  0,1, 0,0,32'h0,        0,4'b0000,0);

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].rst, tbl[i].snap, tbl[i].chk, tbl[i].rest,
            0, tbl[i].l_dmiss, 0, tbl[i].l_inst, 0, tbl[i].r_dmiss, 0, tbl[i].r_inst);
      tick();
      check($sformatf("tbl%0d snap_valid", i), snap_valid, tbl[i].e_sv);
      check($sformatf("tbl%0d restore_valid", i), restore_valid, tbl[i].e_rv);
      check($sformatf("tbl%0d restore_state", i), {rs_irq, rs_inst, rs_dmiss, rs_mem}, {1'b0, tbl[i].e_ri, 2'b00});
      check($sformatf("tbl%0d violation", i), violation, tbl[i].e_v);
      check($sformatf("tbl%0d violation_mask", i), violation_mask, tbl[i].e_m);
      check($sformatf("tbl%0d checked_cycles", i), checked_cycles, exp_cnt(tbl[i].e_cnt, 16));
    end

    // Ten matching compares, then ten more to saturate the 4-bit counter.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 1, 0, 0, 1, 0, 1, 32'hA5A5_0001, 1, 0, 1, 32'hA5A5_0001);
    tick();
    for (int i = 0; i < 20; i++) begin
      logic [31:0] v;
      v = $urandom;
      drive(0, 0, 1, 0, v[0], v[1], v[2], v, v[0], v[1], v[2], v);
      tick();
      if (i == 9) begin
        check("ten compares violation", violation, 1'b0);
        check("ten compares count", checked_cycles, exp_cnt(10, 16));
      end
    end
    check("twenty compares violation", violation, 1'b0);
    check("twenty compares count16", checked_cycles, exp_cnt(20, 16));
    check("twenty compares count4 saturated", checked_cycles_4, exp_cnt(20, 4));

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      bit rst, snap, chk, rest;
      logic [31:0] li;
      logic [2:0] lb;
      logic [34:0] flip;
      rst  = (i == 0) || ($urandom_range(0, 39) == 0);
      snap = !m_checking && ($urandom_range(0, 4) == 0);
      chk  = $urandom_range(0, 1) == 1;
      rest = $urandom_range(0, 3) == 0;
      li   = $urandom;
      lb   = 3'($urandom);
      flip = '0;
      if ($urandom_range(0, 14) == 0) flip[$urandom_range(0, 34)] = 1'b1;
      l_vec = {lb[2], li, lb[1], lb[0]};
      r_vec = l_vec ^ flip;
      drive(rst, snap, chk, rest, l_vec[0], l_vec[1], l_vec[34], l_vec[33:2],
            r_vec[0], r_vec[1], r_vec[34], r_vec[33:2]);
      model_step(rst, snap, chk, rest, l_vec, r_vec);
      tick();
      check("rand snap_valid", snap_valid, m_has_snap);
      check("rand restore_valid", restore_valid, m_rv);
      check("rand restore_state", {rs_irq, rs_inst, rs_dmiss, rs_mem}, m_rdata);
      check("rand violation", violation, m_viol);
      check("rand violation_mask", violation_mask, m_mask);
      check("rand checked_cycles", checked_cycles, exp_cnt(m_cnt, 16));
      check("rand checked_cycles4", checked_cycles_4, exp_cnt(m_cnt, 4));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
